game_screen_seq: RTL and testbench

Parametrised screen/game-flow sequencer for the Pacman top level. It tracks title, play, pause, death, level-clear, game-over and win screens. It also owns the level and lives counters and drives the VGA screen-select mux and the maze/actor reload strobes. Button inputs are edge-detected internally, and timed transition screens are held for a configurable number of video frames.

---
 rtl/game_screen_seq_if.sv | 30 +++
 rtl/game_screen_seq.sv | 154 +++++++++++++++
 tb/tb_game_screen_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/game_screen_seq_if.sv
// Screen/game-flow sequencer bundle: per-frame strobe, buttons and event
// pulses in; screen select, level/lives counters and reload strobes out.
// Latency: none (wires only). Backpressure: none, all signals are level/strobe.
// Ports: master = game-side driver (tb / top level), slave = sequencer.
interface game_screen_seq_if #(
  parameter int LVL_W  = 2,
  parameter int LIFE_W = 2
);
  logic              frame_i;
  logic              start_i;
  logic              pause_i;
  logic              died_i;
  logic              cleared_i;
  logic [2:0]        screen_o;
  logic [LVL_W-1:0]  level_o;
  logic [LIFE_W-1:0] lives_o;
  logic              game_run_o;
  logic              level_load_o;
  logic              respawn_o;

  modport master (
    output frame_i, start_i, pause_i, died_i, cleared_i,
    input  screen_o, level_o, lives_o, game_run_o, level_load_o, respawn_o
  );

  modport slave (
    input  frame_i, start_i, pause_i, died_i, cleared_i,
    output screen_o, level_o, lives_o, game_run_o, level_load_o, respawn_o
  );
endinterface

// File: rtl/game_screen_seq.sv
// Pacman screen/game-flow FSM: title/play/pause/dying/level-clear/game-over/win,
// level + lives counters, maze reload and respawn strobes. Latency: 1 clock
// input-to-output, all outputs registered. Backpressure: none, events never stall.
// Ports: clk_i, reset_ni (async active-low), bus (game_screen_seq_if.slave).
module game_screen_seq #(
  parameter int NUM_LEVELS  = 4,
  parameter int START_LIVES = 3,
  parameter int HOLD_FRAMES = 90,
  parameter int LVL_W       = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  parameter int LIFE_W      = $clog2(START_LIVES + 1)
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  game_screen_seq_if.slave  bus
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [LVL_W-1:0]  LEVEL_LAST = LVL_W'(NUM_LEVELS - 1);
  localparam logic [LIFE_W-1:0] LIVES_INIT = LIFE_W'(START_LIVES);

  typedef enum logic [2:0] {
    S_TITLE       = 3'd0,
    S_PLAY        = 3'd1,
    S_PAUSE       = 3'd2,
    S_DYING       = 3'd3,
    S_LEVEL_CLEAR = 3'd4,
    S_GAME_OVER   = 3'd5,
    S_WIN         = 3'd6
  } screen_e;

  screen_e           state_q, state_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [LIFE_W-1:0] lives_q, lives_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              run_q, run_d;
  logic              load_q, load_d;
  logic              respawn_q, respawn_d;
  logic              start_q, pause_q;

  logic start_rise, pause_rise, hold_done;

  assign start_rise = bus.start_i & ~start_q;
  assign pause_rise = bus.pause_i & ~pause_q;
  // Counter value N-1 on a frame strobe is the N-th frame since entry.
  assign hold_done  = bus.frame_i && (hold_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    lives_d   = lives_q;
    hold_d    = hold_q;
    load_d    = 1'b0;
    respawn_d = 1'b0;

    case (state_q)
      S_TITLE: begin
        if (start_rise) begin
          state_d = S_PLAY;
          level_d = '0;
          lives_d = LIVES_INIT;
          load_d  = 1'b1;
        end
      end

      S_PLAY: begin
        // died beats cleared beats pause; a dropped cleared is not remembered.
        if (bus.died_i) begin
          state_d = S_DYING;
          lives_d = (lives_q != '0) ? lives_q - 1'b1 : '0;
          hold_d  = '0;
        end else if (bus.cleared_i) begin
          state_d = S_LEVEL_CLEAR;
          hold_d  = '0;
        end else if (pause_rise) begin
          state_d = S_PAUSE;
        end
      end

      S_PAUSE: begin
        if (pause_rise || start_rise) state_d = S_PLAY;
      end

      S_DYING: begin
        if (hold_done) begin
          if (lives_q == '0) begin
            state_d = S_GAME_OVER;
          end else begin
            state_d   = S_PLAY;
            respawn_d = 1'b1;
          end
        end else if (bus.frame_i) begin
          hold_d = hold_q + 1'b1;
        end
      end

      S_LEVEL_CLEAR: begin
        if (hold_done) begin
          if (level_q == LEVEL_LAST) begin
            state_d = S_WIN;
          end else begin
            state_d = S_PLAY;
            level_d = level_q + 1'b1;
            load_d  = 1'b1;
          end
        end else if (bus.frame_i) begin
          hold_d = hold_q + 1'b1;
        end
      end

      S_GAME_OVER, S_WIN: begin
        // Final level/lives stay on screen until the player restarts.
        if (start_rise) state_d = S_TITLE;
      end

      default: state_d = S_TITLE;
    endcase

    run_d = (state_d == S_PLAY);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_TITLE;
      level_q   <= '0;
      lives_q   <= '0;
      hold_q    <= '0;
      run_q     <= 1'b0;
      load_q    <= 1'b0;
      respawn_q <= 1'b0;
      // Reset high so a button held through reset needs a fresh press.
      start_q   <= 1'b1;
      pause_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      lives_q   <= lives_d;
      hold_q    <= hold_d;
      run_q     <= run_d;
      load_q    <= load_d;
      respawn_q <= respawn_d;
      start_q   <= bus.start_i;
      pause_q   <= bus.pause_i;
    end
  end

  assign bus.screen_o     = state_q;
  assign bus.level_o      = level_q;
  assign bus.lives_o      = lives_q;
  assign bus.game_run_o   = run_q;
  assign bus.level_load_o = load_q;
  assign bus.respawn_o    = respawn_q;

endmodule

// File: tb/tb_game_screen_seq.sv
// Bench for game_screen_seq (NUM_LEVELS=2, START_LIVES=2, HOLD_FRAMES=2):
// per-cycle input vectors with hand-derived expected outputs, queued when
// driven and compared one clock later, plus an async-reset sequence.
module tb_game_screen_seq;

  localparam int LVL_W  = 1;
  localparam int LIFE_W = 2;

  logic clk_i    = 1'b0;
  logic reset_ni = 1'b0;

  always #5 clk_i = ~clk_i;

  game_screen_seq_if #(.LVL_W(LVL_W), .LIFE_W(LIFE_W)) bus ();

  game_screen_seq #(
    .NUM_LEVELS (2),
    .START_LIVES(2),
    .HOLD_FRAMES(2)
  ) dut (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .bus     (bus)
  );

  typedef struct packed {
    logic [2:0]        scr;
    logic [LVL_W-1:0]  lvl;
    logic [LIFE_W-1:0] liv;
    logic              run;
    logic              load;
    logic              resp;
  } obs_t;

  typedef struct {
    logic st, pa, di, cl, fr;
    obs_t exp;
  } vec_t;

  vec_t vecs[$];
  obs_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  function automatic void add(input logic st, pa, di, cl, fr,
                              input logic [2:0] scr, input int lvl, input int liv,
                              input logic run, load, resp);
    vec_t v;
    v.st = st; v.pa = pa; v.di = di; v.cl = cl; v.fr = fr;
    v.exp = '{scr: scr, lvl: LVL_W'(lvl), liv: LIFE_W'(liv),
              run: run, load: load, resp: resp};
    vecs.push_back(v);
  endfunction

  task automatic check_now(input string tag, input int idx);
    obs_t got, e;
    got = '{scr: bus.screen_o, lvl: bus.level_o, liv: bus.lives_o,
            run: bus.game_run_o, load: bus.level_load_o, resp: bus.respawn_o};
    tests++;
    if (exp_q.size() == 0) begin
      failed++;
      $display("FAIL %s[%0d]: scoreboard empty, got scr=%0d", tag, idx, got.scr);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        failed++;
        $display("FAIL %s[%0d]: got scr=%0d lvl=%0d liv=%0d run=%b load=%b resp=%b, want scr=%0d lvl=%0d liv=%0d run=%b load=%b resp=%b",
                 tag, idx, got.scr, got.lvl, got.liv, got.run, got.load, got.resp,
                 e.scr, e.lvl, e.liv, e.run, e.load, e.resp);
      end
    end
  endtask

  task automatic drive(input logic st, pa, di, cl, fr);
    bus.start_i   = st;
    bus.pause_i   = pa;
    bus.died_i    = di;
    bus.cleared_i = cl;
    bus.frame_i   = fr;
  endtask

  task automatic apply(input vec_t v, input string tag, input int idx);
    drive(v.st, v.pa, v.di, v.cl, v.fr);
    exp_q.push_back(v.exp);
    @(posedge clk_i);
    #1;
    check_now(tag, idx);
  endtask

  localparam obs_t RST_OBS = '0;

  initial begin
    //  st pa di cl fr   scr lvl liv run load resp
    // start held through reset: no rise until released and pressed again
    add(1, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0);   // 0
    add(0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0);
    add(1, 0, 0, 0, 0,   1, 0, 2,  1, 1, 0);   // start -> PLAY, load
    add(1, 0, 0, 0, 0,   1, 0, 2,  1, 0, 0);
    add(0, 0, 0, 0, 0,   1, 0, 2,  1, 0, 0);
    // level clear, 2-frame hold, next level
    add(0, 0, 0, 1, 0,   4, 0, 2,  0, 0, 0);   // 5
    add(0, 0, 0, 0, 1,   4, 0, 2,  0, 0, 0);
    add(0, 0, 0, 0, 0,   4, 0, 2,  0, 0, 0);
    add(0, 0, 0, 0, 1,   1, 1, 2,  1, 1, 0);
    add(0, 0, 0, 0, 0,   1, 1, 2,  1, 0, 0);
    // last level cleared -> WIN, level stays 1
    add(0, 0, 0, 1, 0,   4, 1, 2,  0, 0, 0);   // 10
    add(0, 0, 0, 0, 1,   4, 1, 2,  0, 0, 0);
    add(0, 0, 0, 0, 1,   6, 1, 2,  0, 0, 0);
    add(0, 0, 0, 0, 1,   6, 1, 2,  0, 0, 0);
    add(1, 0, 0, 0, 0,   0, 1, 2,  0, 0, 0);   // WIN -> TITLE, counters held
    add(0, 0, 0, 0, 0,   0, 1, 2,  0, 0, 0);   // 15
    add(1, 0, 0, 0, 0,   1, 0, 2,  1, 1, 0);
    // death with respawn, then death to GAME_OVER
    add(0, 0, 1, 0, 0,   3, 0, 1,  0, 0, 0);
    add(0, 0, 0, 0, 1,   3, 0, 1,  0, 0, 0);
    add(0, 0, 0, 0, 1,   1, 0, 1,  1, 0, 1);
    add(0, 0, 0, 0, 0,   1, 0, 1,  1, 0, 0);   // 20
    add(0, 0, 1, 0, 0,   3, 0, 0,  0, 0, 0);
    add(0, 0, 0, 0, 1,   3, 0, 0,  0, 0, 0);
    add(0, 0, 0, 0, 1,   5, 0, 0,  0, 0, 0);
    add(1, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0);
    add(0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0);   // 25
    add(1, 0, 0, 0, 0,   1, 0, 2,  1, 1, 0);
    // pause; died/cleared ignored; start resumes without pulses
    add(0, 1, 0, 0, 0,   2, 0, 2,  0, 0, 0);
    add(0, 1, 1, 0, 0,   2, 0, 2,  0, 0, 0);
    add(0, 0, 0, 1, 0,   2, 0, 2,  0, 0, 0);
    add(1, 0, 0, 0, 0,   1, 0, 2,  1, 0, 0);   // 30
    // died + cleared together: died wins, level never advances
    add(0, 0, 1, 1, 0,   3, 0, 1,  0, 0, 0);
    add(0, 0, 0, 0, 1,   3, 0, 1,  0, 0, 0);
    add(0, 0, 0, 0, 1,   1, 0, 1,  1, 0, 1);
    // pause rise with died -> DYING; entry-cycle frame is not counted
    add(0, 1, 1, 0, 1,   3, 0, 0,  0, 0, 0);
    add(0, 0, 0, 0, 1,   3, 0, 0,  0, 0, 0);   // 35
    add(0, 0, 0, 0, 1,   5, 0, 0,  0, 0, 0);
    add(1, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0);
    add(0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0);
    add(1, 0, 0, 0, 0,   1, 0, 2,  1, 1, 0);
    add(0, 0, 1, 0, 0,   3, 0, 1,  0, 0, 0);   // 40
    add(0, 0, 0, 0, 1,   3, 0, 1,  0, 0, 0);   // one frame counted

    drive(1, 0, 0, 0, 0);
    repeat (3) @(posedge clk_i);
    #1;
    exp_q.push_back(RST_OBS);
    check_now("reset", 0);
    reset_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], "vec", i);

    // Mid-DYING async reset: outputs clear without any clock edge.
    #2;
    reset_ni = 1'b0;
    #1;
    exp_q.push_back(RST_OBS);
    check_now("async_rst", 0);
    @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(RST_OBS);
      @(posedge clk_i);
      #1;
      check_now("post_rst", i);
    end

    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
